// File: rtl/key_filter.sv
// Debounce filter for one active-low push-button.
// Emits a clean level plus one-cycle press, release and long-press pulses.
module key_filter #(
  parameter int CNT_MAX  = 1_000_000,
  parameter int LONG_MAX = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = $clog2(CNT_MAX);
  localparam int LW = $clog2(LONG_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_MAX);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    DOWN,
    REL_FILT
  } state_e;

  state_e state_q, state_d;

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  // Two-flop synchroniser; the pin idles high (released).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= key_in;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lcnt_d    = lcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!s2_q) begin
          state_d = PRESS_FILT;
          cnt_d   = '0;
        end
      end
      PRESS_FILT: begin
        if (s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          level_d = 1'b1;
          press_d = 1'b1;
          lcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOWN: begin
        if (s2_q) begin
          state_d = REL_FILT;
          cnt_d   = '0;
        end
      end
      REL_FILT: begin
        if (!s2_q) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Saturating hold counter keeps the long pulse to one per press.
    if (state_q == DOWN || state_q == REL_FILT) begin
      if (lcnt_q == LONG_LAST) long_d = 1'b1;
      if (lcnt_q < LONG_SAT) lcnt_d = lcnt_q + LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lcnt_q    <= lcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed edge timings.
module tb_key_filter;

  localparam int CNT_MAX  = 10;
  localparam int LONG_MAX = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b1;
  logic key_level, key_press, key_release, key_long;

  int errors = 0;
  int checks = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int cur = -1;
  int p0, r0, l0;

  key_filter #(
    .CNT_MAX (CNT_MAX),
    .LONG_MAX(LONG_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #10 clk = ~clk;

  // Reference: a level flips once the synchronised pin has disagreed
  // with it for CNT_MAX+1 consecutive edges; long fires on the
  // LONG_MAX-th edge spent pressed.
  logic m_s1 = 1'b1, m_s2 = 1'b1, m_level = 1'b0;
  logic e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0;
  int   m_run = 0, m_held = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= 1'b1; m_s2 <= 1'b1; m_level <= 1'b0;
      m_run <= 0; m_held <= 0;
      e_press <= 1'b0; e_rel <= 1'b0; e_long <= 1'b0;
    end else begin
      e_press <= 1'b0; e_rel <= 1'b0; e_long <= 1'b0;
      m_s1 <= key_in;
      m_s2 <= m_s1;
      if ((!m_s2) != m_level) begin
        if (m_run + 1 == CNT_MAX + 1) begin
          m_level <= ~m_level;
          m_run <= 0;
          if (!m_level) begin
            e_press <= 1'b1;
            m_held <= 0;
          end else begin
            e_rel <= 1'b1;
          end
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
      if (m_level) begin
        if (m_held + 1 == LONG_MAX) e_long <= 1'b1;
        m_held <= m_held + 1;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({key_level, key_press, key_release, key_long} !==
        {m_level, e_press, e_rel, e_long}) begin
      errors++;
      $display("FAIL model t=%0t got lvl/prs/rel/lng=%b%b%b%b expected %b%b%b%b",
               $time, key_level, key_press, key_release, key_long,
               m_level, e_press, e_rel, e_long);
    end
    if (key_press) n_press++;
    if (key_release) n_rel++;
    if (key_long) n_long++;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge 0 is the first posedge after the drive.
  task automatic drive(input logic v);
    @(posedge clk);
    #5 key_in = v;
    cur = -1;
  endtask

  task automatic to_edge(input int e);
    while (cur < e) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  // Hold v for exactly n sampling edges.
  task automatic run(input logic v, input int n);
    drive(v);
    to_edge(n - 2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", key_level, 1'b0);
    chk("rst_press", key_press, 1'b0);
    chk("rst_release", key_release, 1'b0);
    chk("rst_long", key_long, 1'b0);
    @(posedge clk);
    #5 rst = 1'b0;

    // clean press
    p0 = n_press; l0 = n_long;
    drive(1'b0);
    to_edge(11);
    chk("press_e11", key_press, 1'b0);
    chk("level_e11", key_level, 1'b0);
    to_edge(12);
    chk("press_e12", key_press, 1'b1);
    chk("level_e12", key_level, 1'b1);
    to_edge(13);
    chk("press_e13", key_press, 1'b0);
    to_edge(29);
    chk_n("press_count", n_press - p0, 1);

    // clean release
    r0 = n_rel;
    drive(1'b1);
    to_edge(11);
    chk("rel_e11", key_release, 1'b0);
    chk("rel_level_e11", key_level, 1'b1);
    to_edge(12);
    chk("rel_e12", key_release, 1'b1);
    chk("rel_level_e12", key_level, 1'b0);
    to_edge(20);
    chk_n("rel_count", n_rel - r0, 1);
    chk_n("short_no_long", n_long - l0, 0);

    // bounce rejection
    p0 = n_press;
    run(1'b0, 5);
    run(1'b1, 3);
    run(1'b0, 9);
    run(1'b1, 20);
    chk_n("bounce_press", n_press - p0, 0);
    chk("bounce_level", key_level, 1'b0);

    // release bounce
    run(1'b0, 16);
    chk("rb_level_down", key_level, 1'b1);
    r0 = n_rel; l0 = n_long;
    run(1'b1, 6);
    run(1'b0, 10);
    chk_n("rb_no_release", n_rel - r0, 0);
    chk("rb_level_held", key_level, 1'b1);
    drive(1'b1);
    to_edge(11);
    chk("rb_rel_e11", key_release, 1'b0);
    to_edge(12);
    chk("rb_rel_e12", key_release, 1'b1);
    chk("rb_level_e12", key_level, 1'b0);
    to_edge(16);
    chk_n("rb_rel_count", n_rel - r0, 1);
    chk_n("rb_no_long", n_long - l0, 0);

    // long press
    p0 = n_press; r0 = n_rel; l0 = n_long;
    drive(1'b0);
    to_edge(12);
    chk("lp_press_e12", key_press, 1'b1);
    to_edge(51);
    chk("lp_long_e51", key_long, 1'b0);
    to_edge(52);
    chk("lp_long_e52", key_long, 1'b1);
    to_edge(53);
    chk("lp_long_e53", key_long, 1'b0);
    to_edge(99);
    drive(1'b1);
    to_edge(12);
    chk("lp_rel_e12", key_release, 1'b1);
    to_edge(20);
    chk_n("lp_long_count", n_long - l0, 1);
    chk_n("lp_rel_count", n_rel - r0, 1);
    chk_n("lp_press_count", n_press - p0, 1);

    // reset mid-press
    p0 = n_press; r0 = n_rel;
    drive(1'b0);
    to_edge(19);
    chk("mr_level_pre", key_level, 1'b1);
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    chk("mr_level_rst", key_level, 1'b0);
    chk("mr_press_rst", key_press, 1'b0);
    chk("mr_rel_rst", key_release, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #5 rst = 1'b0;
    cur = -1;
    to_edge(11);
    chk("mr_press_e11", key_press, 1'b0);
    to_edge(12);
    chk("mr_press_e12", key_press, 1'b1);
    chk("mr_level_e12", key_level, 1'b1);
    to_edge(14);
    chk_n("mr_no_release", n_rel - r0, 0);
    chk_n("mr_press_count", n_press - p0, 2);
    drive(1'b1);
    to_edge(14);
    chk_n("mr_final_rel", n_rel - r0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Input-side counterpart to the LED drivers: debounces one active-low board push-button and produces clean level and event outputs for downstream logic (LED control, mode select).
- Synchronises the raw pin, filters contact bounce with a stability counter, and emits one-cycle press, release and long-press pulses.
- Sits directly behind the key pin; one instance per key.

Parameters:
- CNT_MAX, 1_000_000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range >= 2.
- LONG_MAX, 50_000_000, cycles held in the accepted-pressed condition before the long-press pulse (1 s at 50 MHz); legal range >= 2.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset; asynchronous, active-high.
- key_in  input  1  raw button pin, active-low (0 = pressed), asynchronous to clk.
- key_level  output  1  debounced state, 1 = pressed.
- key_press  output  1  one-cycle pulse when a press is accepted.
- key_release  output  1  one-cycle pulse when a release is accepted.
- key_long  output  1  one-cycle pulse when the hold reaches LONG_MAX cycles; at most once per press.

Behaviour:
- Reset (async, active-high) forces:
  - sync flops s1 and s2 to 1 (released);
  - state to IDLE;
  - cnt and lcnt to 0;
  - all four outputs to 0.
- Synchroniser: s1 <= key_in, s2 <= s1. Only s2 is used downstream.
- Counter widths: cnt is $clog2(CNT_MAX) bits; lcnt is $clog2(LONG_MAX+1) bits.
- All outputs are registered. key_press, key_release and key_long default to 0 every cycle.
- FSM states and transitions, evaluated each rising clk edge:
  - IDLE (key_level = 0):
    - s2 = 0 -> PRESS_FILT, cnt <= 0.
  - PRESS_FILT:
    - s2 = 1 -> IDLE, cnt <= 0 (bounce rejected; no output).
    - else cnt = CNT_MAX-1 -> DOWN, key_level <= 1, key_press <= 1, lcnt <= 0.
    - else cnt <= cnt+1.
  - DOWN (key_level = 1):
    - s2 = 1 -> REL_FILT, cnt <= 0.
  - REL_FILT (key_level stays 1):
    - s2 = 0 -> DOWN; cnt and lcnt are not cleared.
    - else cnt = CNT_MAX-1 -> IDLE, key_level <= 0, key_release <= 1.
    - else cnt <= cnt+1.
- Long-press counter, in DOWN and REL_FILT:
  - lcnt increments each cycle while lcnt < LONG_MAX; it saturates at LONG_MAX.
  - On the edge where lcnt = LONG_MAX-1, key_long <= 1.
  - Saturation guarantees a single key_long pulse per press.
- Latency. Edge 0 is the first rising edge sampling key_in low, after which key_in is held stable:
  - key_press and key_level rise at edge CNT_MAX+2.
  - key_long rises at edge CNT_MAX+2+LONG_MAX.
  - Release mirrors this: key_release rises and key_level falls at edge CNT_MAX+2 after key_in is first sampled high.
- Boundaries:
  - A glitch shorter than CNT_MAX cycles produces no output and restarts the filter.
  - A release shorter than CNT_MAX cycles during DOWN does not end the press and does not restart lcnt.
  - Release before LONG_MAX: no key_long.
  - key_press and key_release never assert in the same cycle.
  - key_long never coincides with key_press; it can precede key_release by any amount.
  - Reset mid-press returns to IDLE with outputs at 0 and no release pulse.
  - If key_in is still low after reset deasserts, a full new filter period runs before key_press.

Test Plan (CNT_MAX = 10, LONG_MAX = 40, clk 20 ns):
- Clean press: key_in 1->0 held 30 cycles -> key_press single pulse at edge 12; key_level = 1 from edge 12; no key_long.
- Bounce rejection: key_in low 5 cycles, high 3, low 9, then high -> no key_press; key_level stays 0 throughout.
- Clean release after the clean press: key_in 0->1 held -> key_release single pulse and key_level 0 at edge 12 after the first high sample.
- Release bounce: during DOWN, key_in high 6 cycles then low again -> key_level stays 1, no key_release; a later clean release is accepted normally.
- Long press: key_in low held 100 cycles -> key_press at edge 12, key_long single pulse at edge 52, then exactly one key_release after release.
- Reset mid-press: assert rst at cycle 20 of a held press for 2 cycles, key_in kept low -> outputs 0 immediately; key_press again 12 edges after the first post-reset sample; no key_release emitted.
